// File: rtl/alarm_pkg.sv
// Shared state encoding, counter sizing and parameter sanity helpers for the
// multi-zone alarm controller.
package alarm_pkg;

    localparam int STATE_W = 3;

    // Low two bits keep the legacy single-input controller codes.
    typedef enum logic [STATE_W-1:0] {
        ST_OFF       = 3'b000,
        ST_ARMED     = 3'b001,
        ST_TRIGGERED = 3'b010,
        ST_ALARM_ON  = 3'b011,
        ST_EXIT_WAIT = 3'b100
    } alarm_state_e;

    function automatic int cnt_width(int exit_d, int entry_d, int timeout_d);
        int max_d;
        max_d = exit_d;
        if (entry_d > max_d) max_d = entry_d;
        if (timeout_d > max_d) max_d = timeout_d;
        return $clog2(max_d) + 1;
    endfunction

    function automatic bit params_ok(int n_zones, int exit_d, int entry_d);
        return (n_zones >= 1) && (n_zones <= 8) && (exit_d >= 1) && (entry_d >= 1);
    endfunction

endpackage

// File: rtl/alarm_delay_counter.sv
// Down-counter shared by the exit, entry and alarm-timeout phases.
// Decrement saturates at zero; load takes priority over decrement.
module alarm_delay_counter #(
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             is_zero
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (ena) begin
            if (load) begin
                cnt_q <= load_val;
            end else if (dec && (cnt_q != '0)) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    assign cnt     = cnt_q;
    assign is_zero = (cnt_q == '0);

endmodule

// File: rtl/multi_zone_alarm_ctrl.sv
// Multi-zone alarm supervisor: exit/entry delays, instant zones, alarm
// auto-timeout with re-arm, and a sticky record of the zones that tripped.
module multi_zone_alarm_ctrl
    import alarm_pkg::*;
#(
    parameter int                 N_ZONES       = 4,
    parameter logic [N_ZONES-1:0] INSTANT_MASK  = N_ZONES'(4'b1000),
    parameter int                 EXIT_DELAY    = 16,
    parameter int                 ENTRY_DELAY   = 16,
    parameter int                 ALARM_TIMEOUT = 64,
    parameter int                 CNT_W         = cnt_width(EXIT_DELAY, ENTRY_DELAY, ALARM_TIMEOUT)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ena,
    input  logic               arm,
    input  logic               disarm,
    input  logic [N_ZONES-1:0] sensor,
    input  logic [N_ZONES-1:0] zone_en,
    output logic [STATE_W-1:0] state,
    output logic [STATE_W-1:0] next_state,
    output logic               alarm,
    output logic [N_ZONES-1:0] zone_latched,
    output logic [CNT_W-1:0]   delay_cnt
);

    if (!params_ok(N_ZONES, EXIT_DELAY, ENTRY_DELAY)) begin : g_param_err
        $error("multi_zone_alarm_ctrl: need 1<=N_ZONES<=8, EXIT_DELAY>=1, ENTRY_DELAY>=1");
    end

    localparam bit               HAS_TIMEOUT = (ALARM_TIMEOUT > 0);
    localparam logic [CNT_W-1:0] EXIT_LD     = CNT_W'(EXIT_DELAY - 1);
    localparam logic [CNT_W-1:0] ENTRY_LD    = CNT_W'(ENTRY_DELAY - 1);
    localparam logic [CNT_W-1:0] ALARM_LD    = HAS_TIMEOUT ? CNT_W'(ALARM_TIMEOUT - 1) : '0;

    alarm_state_e       state_q, state_d;
    logic               alarm_q;
    logic [N_ZONES-1:0] latched_q, latched_d;
    logic [N_ZONES-1:0] act, inst, dly;
    logic               cnt_load, cnt_dec, cnt_zero;
    logic [CNT_W-1:0]   cnt_load_val;

    assign act  = sensor & zone_en;
    assign inst = act & INSTANT_MASK;
    assign dly  = act & ~INSTANT_MASK;

    alarm_delay_counter #(
        .CNT_W(CNT_W)
    ) u_delay_counter (
        .clk      (clk),
        .rst      (rst),
        .ena      (ena),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .cnt      (delay_cnt),
        .is_zero  (cnt_zero)
    );

    always_comb begin
        state_d      = state_q;
        latched_d    = latched_q;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_dec      = 1'b0;

        if (disarm) begin
            state_d  = ST_OFF;
            cnt_load = 1'b1;
        end else begin
            case (state_q)
                ST_OFF: begin
                    if (arm) begin
                        state_d      = ST_EXIT_WAIT;
                        cnt_load     = 1'b1;
                        cnt_load_val = EXIT_LD;
                        latched_d    = '0;
                    end
                end
                ST_EXIT_WAIT: begin
                    if (cnt_zero) state_d = ST_ARMED;
                    else          cnt_dec = 1'b1;
                end
                ST_ARMED: begin
                    latched_d = latched_q | act;
                    if (|inst) begin
                        state_d      = ST_ALARM_ON;
                        cnt_load     = 1'b1;
                        cnt_load_val = ALARM_LD;
                    end else if (|dly) begin
                        state_d      = ST_TRIGGERED;
                        cnt_load     = 1'b1;
                        cnt_load_val = ENTRY_LD;
                    end
                end
                ST_TRIGGERED: begin
                    // Once started, the entry delay runs out even if the sensor clears.
                    latched_d = latched_q | act;
                    if ((|inst) || cnt_zero) begin
                        state_d      = ST_ALARM_ON;
                        cnt_load     = 1'b1;
                        cnt_load_val = ALARM_LD;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
                ST_ALARM_ON: begin
                    if (HAS_TIMEOUT) begin
                        if (cnt_zero) state_d = ST_ARMED;
                        else          cnt_dec = 1'b1;
                    end
                end
                default: begin
                    state_d  = ST_OFF;
                    cnt_load = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_OFF;
            alarm_q   <= 1'b0;
            latched_q <= '0;
        end else if (ena) begin
            state_q   <= state_d;
            alarm_q   <= (state_d == ST_ALARM_ON);
            latched_q <= latched_d;
        end
    end

    assign state        = state_q;
    assign next_state   = ena ? state_d : state_q;
    assign alarm        = alarm_q;
    assign zone_latched = latched_q;

endmodule
